// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and widths for the note-game sequence loader.
package game_pkg;
    typedef enum logic [3:0] {
        IDLE, CLEAR, GEN, WRITE, GAP, START, PLAY, DONE, CLEAR_ABORT
    } state_e;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int NIBBLE_W = 4;
    localparam int NOTE_W = 3;
    localparam int DATA_W = 32;
endpackage

// File: rtl/note_lfsr.sv
// note_lfsr: free-running 16-bit Galois LFSR that reloads SEED instead of locking at zero.
module note_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);
    logic [15:0] value_q, value_d, shifted;

    assign shifted = (value_q >> 1) ^ (value_q[0] ? LFSR_MASK : 16'h0000);
    assign value_d = (shifted == 16'h0000) ? SEED : shifted;
    assign value = value_q;

    always_ff @(posedge clk) begin
        if (!reset) value_q <= SEED;
        else value_q <= value_d;
    end
endmodule

// File: rtl/game_sequence_loader.sv
// game_sequence_loader: builds a random note pattern, loads it into the game core,
// starts the game and counts completed games.
module game_sequence_loader
    import game_pkg::*;
#(
    parameter int          NOTE_COUNT  = 8,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          START_DELAY = 4,
    parameter bit          NO_REPEAT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              abort,
    input  logic              game_end,
    output logic              game_reset,
    output logic [DATA_W-1:0] data_out,
    output logic              write_enable,
    output logic              game_start,
    output logic              busy,
    output logic [7:0]        game_count
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        idx_q, idx_d;
    logic [NOTE_W-1:0] prev_q, prev_d, raw, note;
    logic [3:0]        dly_q, dly_d;
    logic [7:0]        count_q, count_d;
    logic [15:0]       lfsr;
    logic [12:0]       unused_lfsr;

    note_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .value(lfsr));

    assign raw = lfsr[NOTE_W-1:0];
    assign unused_lfsr = lfsr[15:NOTE_W];
    // Repeat avoidance compares against the previously written note, not the raw one.
    assign note = (NO_REPEAT && idx_q != 3'd0 && raw == prev_q) ? raw + 3'd1 : raw;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        dly_d   = dly_q;
        count_d = count_q;
        case (state_q)
            IDLE:  state_d = new_game ? CLEAR : IDLE;
            CLEAR: begin
                data_d  = '0;
                idx_d   = 3'd0;
                state_d = GEN;
            end
            GEN: begin
                data_d[idx_q*NIBBLE_W +: NIBBLE_W] = {1'b0, note};
                prev_d  = note;
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'(NOTE_COUNT - 1)) ? WRITE : GEN;
            end
            WRITE: begin
                dly_d   = 4'(START_DELAY);
                state_d = GAP;
            end
            GAP: begin
                dly_d   = dly_q - 4'd1;
                state_d = (dly_q == 4'd1) ? START : GAP;
            end
            START: state_d = PLAY;
            PLAY:  state_d = game_end ? DONE : PLAY;
            DONE: begin
                count_d = (count_q != 8'hFF && !abort) ? count_q + 8'd1 : count_q;
                state_d = IDLE;
            end
            CLEAR_ABORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE && state_q != CLEAR_ABORT) state_d = CLEAR_ABORT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= 3'd0;
            prev_q  <= '0;
            dly_q   <= 4'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            dly_q   <= dly_d;
            count_q <= count_d;
        end
    end

    assign game_reset   = (state_q == CLEAR) || (state_q == CLEAR_ABORT);
    assign write_enable = (state_q == WRITE);
    assign game_start   = (state_q == START);
    assign busy         = (state_q != IDLE);
    assign data_out     = data_q;
    assign game_count   = count_q;
endmodule
